flatten_stream_ctrl: RTL and testbench

Sequencer that turns CHANNELS parallel ROW x COL feature maps into one serial, flattened element stream for the dense/FC stage. It accepts one map per valid/ready handshake, latches it, and emits its elements in row-major order. Global flat index = ch*ROW*COL + i*COL + j. It flags the last element of the frame and pulses done when the frame ends.

---
 rtl/flatten_stream_if.sv | 28 ++
 rtl/flatten_stream_ctrl.sv | 125 ++++++++++++
 tb/tb_flatten_stream_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flatten_stream_if.sv
// Handshake bundle for flatten_stream_ctrl: map input stream and flattened element output stream.
// The master modport is the controller's view; slave is the environment driving maps and draining elements.
interface flatten_stream_if #(
   parameter int ROW        = 6,
   parameter int COL        = 6,
   parameter int CHANNELS   = 4,
   parameter int DATA_WIDTH = 8,
   parameter int IDX_W      = ($clog2(CHANNELS*ROW*COL) > 1) ? $clog2(CHANNELS*ROW*COL) : 1
);
   logic                          in_valid;
   logic                          in_ready;
   logic [ROW*COL*DATA_WIDTH-1:0] in_map;
   logic                          out_valid;
   logic                          out_ready;
   logic [DATA_WIDTH-1:0]         out_data;
   logic [IDX_W-1:0]              out_index;
   logic                          out_last;

   modport master (
      input  in_valid, in_map, out_ready,
      output in_ready, out_valid, out_data, out_index, out_last
   );

   modport slave (
      output in_valid, in_map, out_ready,
      input  in_ready, out_valid, out_data, out_index, out_last
   );
endinterface

// File: rtl/flatten_stream_ctrl.sv
// Latches one ROW x COL channel map per handshake and streams its elements in row-major order,
// tagging each with its global flat index; flags the frame's final element and pulses done after it.
module flatten_stream_ctrl #(
   parameter int ROW        = 6,
   parameter int COL        = 6,
   parameter int CHANNELS   = 4,
   parameter int DATA_WIDTH = 8,
   parameter int IDX_W      = ($clog2(CHANNELS*ROW*COL) > 1) ? $clog2(CHANNELS*ROW*COL) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   flatten_stream_if.master bus,
   output logic             done,
   output logic             busy
);

   localparam int NELEM = ROW * COL;
   localparam int EW    = ($clog2(NELEM) > 1) ? $clog2(NELEM) : 1;
   localparam int CW    = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t                      state;
   state_t                      next_state;
   logic [EW-1:0]               elem_cnt;
   logic [CW-1:0]               ch_cnt;
   logic [NELEM*DATA_WIDTH-1:0] map_buf;
   logic                        done_q;

   logic accept;
   logic out_fire;
   logic last_elem;
   logic last_ch;

   assign accept    = bus.in_valid & bus.in_ready;
   assign out_fire  = bus.out_valid & bus.out_ready;
   assign last_elem = (elem_cnt == EW'(NELEM - 1));
   assign last_ch   = (ch_cnt == CW'(CHANNELS - 1));

   // NOTE: sequential state is written with non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // NOTE: next_state takes a default before any branch so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept)                next_state = STREAM;
            STREAM:  if (out_fire && last_elem) next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Element outputs are forced to zero outside STREAM so the idle bus never shows stale map data.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_index = '0;
      bus.out_last  = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
         end
         STREAM: begin
            bus.out_valid = 1'b1;
            bus.out_data  = map_buf[int'(elem_cnt)*DATA_WIDTH +: DATA_WIDTH];
            bus.out_index = IDX_W'(ch_cnt) * IDX_W'(NELEM) + IDX_W'(elem_cnt);
            bus.out_last  = last_ch & last_elem;
         end
         default: begin
            bus.in_ready = 1'b0;
         end
      endcase
   end

   // NOTE: the map buffer is a plain register bank, not a RAM macro, so it can be cleared on
   // reset; a flush leaves it untouched because its contents are never shown outside STREAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         elem_cnt <= '0;
         ch_cnt   <= '0;
         map_buf  <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            elem_cnt <= '0;
            ch_cnt   <= '0;
         end else if (accept) begin
            map_buf  <= bus.in_map;
            elem_cnt <= '0;
         end else if (out_fire) begin
            if (!last_elem) begin
               elem_cnt <= elem_cnt + EW'(1);
            end else begin
               elem_cnt <= '0;
               if (last_ch) begin
                  ch_cnt <= '0;
                  done_q <= 1'b1;
               end else begin
                  ch_cnt <= ch_cnt + CW'(1);
               end
            end
         end
      end
   end

   // A frame stays busy across the idle bubble between its maps because ch_cnt is nonzero there.
   assign done = done_q;
   assign busy = (ch_cnt != '0) | (state == STREAM);

endmodule

// File: tb/tb_flatten_stream_ctrl.sv
// Scoreboard bench for flatten_stream_ctrl: accepted maps push their expected element stream,
// output handshakes pop and compare; scenario tasks add their own inline checks.
`timescale 1ns/1ps
module tb_flatten_stream_ctrl;

   localparam int ROW        = 6;
   localparam int COL        = 6;
   localparam int CHANNELS   = 4;
   localparam int DATA_WIDTH = 8;
   localparam int NELEM      = ROW * COL;
   localparam int IDX_W      = ($clog2(CHANNELS*NELEM) > 1) ? $clog2(CHANNELS*NELEM) : 1;

   typedef logic [NELEM*DATA_WIDTH-1:0] map_t;
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [IDX_W-1:0]      index;
      logic                  last;
   } elem_t;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic flush = 1'b0;
   logic done;
   logic busy;

   flatten_stream_if #(
      .ROW(ROW), .COL(COL), .CHANNELS(CHANNELS), .DATA_WIDTH(DATA_WIDTH)
   ) bus ();

   flatten_stream_ctrl #(
      .ROW(ROW), .COL(COL), .CHANNELS(CHANNELS), .DATA_WIDTH(DATA_WIDTH)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .flush(flush),
      .bus  (bus),
      .done (done),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail   = 0;
   elem_t sb[$];
   int    tb_ch     = 0;
   bit    mon_en    = 1'b0;
   bit    exp_done  = 1'b0;
   bit    stall_q   = 1'b0;
   elem_t stall_val;
   int    n_pop     = 0;
   int    n_done    = 0;
   int    cyc       = 0;
   int    first_acc = 0;
   int    done_cyc  = 0;

   function automatic map_t make_map(input int base);
      map_t m;
      for (int k = 0; k < NELEM; k++) m[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(base + k);
      return m;
   endfunction

   // Compares the current outputs against the model, then advances the model for the coming edge.
   task automatic monitor();
      elem_t got;
      elem_t e;
      map_t  m;
      if (!mon_en) return;
      got.data  = bus.out_data;
      got.index = bus.out_index;
      got.last  = bus.out_last;

      n_checks++;
      if (bus.out_valid !== (sb.size() != 0)) begin
         n_fail++;
         $display("FAIL out_valid: got %b expected %b (cycle %0d)", bus.out_valid, sb.size() != 0, cyc);
      end
      n_checks++;
      if (bus.in_ready !== (sb.size() == 0)) begin
         n_fail++;
         $display("FAIL in_ready: got %b expected %b (cycle %0d)", bus.in_ready, sb.size() == 0, cyc);
      end
      n_checks++;
      if (busy !== (tb_ch != 0 || sb.size() != 0)) begin
         n_fail++;
         $display("FAIL busy: got %b expected %b (cycle %0d)", busy, tb_ch != 0 || sb.size() != 0, cyc);
      end
      n_checks++;
      if (done !== exp_done) begin
         n_fail++;
         $display("FAIL done: got %b expected %b (cycle %0d)", done, exp_done, cyc);
      end
      if (done === 1'b1) begin
         n_done++;
         done_cyc = cyc;
      end
      if (stall_q) begin
         n_checks++;
         if (bus.out_valid !== 1'b1 || got !== stall_val) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%b %h expected valid=1 %h (cycle %0d)",
                     bus.out_valid, got, stall_val, cyc);
         end
      end

      exp_done = 1'b0;
      stall_q  = 1'b0;
      if (rst || flush) begin
         sb.delete();
         tb_ch = 0;
      end else begin
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL extra_element: got %h expected no element (cycle %0d)", got, cyc);
            end else begin
               e = sb.pop_front();
               n_pop++;
               if (got !== e) begin
                  n_fail++;
                  $display("FAIL element: got data=%0d idx=%0d last=%b expected data=%0d idx=%0d last=%b",
                           got.data, got.index, got.last, e.data, e.index, e.last);
               end
               if (e.last) exp_done = 1'b1;
            end
         end else if (bus.out_valid === 1'b1) begin
            stall_q   = 1'b1;
            stall_val = got;
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            if (tb_ch == 0) first_acc = cyc + 1;
            m = bus.in_map;
            for (int k = 0; k < NELEM; k++) begin
               e.data  = m[k*DATA_WIDTH +: DATA_WIDTH];
               e.index = IDX_W'(tb_ch*NELEM + k);
               e.last  = (tb_ch == CHANNELS-1) && (k == NELEM-1);
               sb.push_back(e);
            end
            tb_ch = (tb_ch + 1) % CHANNELS;
         end
      end
   endtask

   // Inputs change 1 ns after the rising edge; the scoreboard samples on the falling edge.
   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      repeat (2) step();
      rst = 1'b0;
   endtask

   task automatic send_map(input map_t m);
      bus.in_map   = m;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (bus.in_ready === 1'b1) begin
            step();
            bus.in_valid = 1'b0;
            return;
         end
         step();
      end
      bus.in_valid = 1'b0;
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=%b expected 1 within 500 cycles", bus.in_ready);
   endtask

   task automatic drain(input bit random_ready);
      for (int i = 0; i < 3000; i++) begin
         if (sb.size() == 0) return;
         if (random_ready) bus.out_ready = 1'($urandom_range(0, 1));
         step();
      end
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d elements pending expected 0", sb.size());
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.in_map    = '0;
      bus.out_ready = 1'b0;
      do_reset();
      n_checks++;
      if ({bus.in_ready, bus.out_valid, busy, done} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got ready/valid/busy/done=%b expected 1000",
                  {bus.in_ready, bus.out_valid, busy, done});
      end
      n_checks++;
      if ({bus.out_data, bus.out_index, bus.out_last} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got data=%0d idx=%0d last=%b expected 0 0 0",
                  bus.out_data, bus.out_index, bus.out_last);
      end
      mon_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_valid: got %b expected 0", bus.out_valid);
         end
      end
   endtask

   task automatic test_single_map();
      int p0;
      int d0;
      do_reset();
      bus.out_ready = 1'b1;
      p0 = n_pop;
      d0 = n_done;
      send_map(make_map(0));
      n_checks++;
      if ({bus.out_valid, bus.out_data, bus.out_index} !== {1'b1, 8'd0, IDX_W'(0)}) begin
         n_fail++;
         $display("FAIL first_latency: got valid=%b data=%0d idx=%0d expected 1 0 0",
                  bus.out_valid, bus.out_data, bus.out_index);
      end
      drain(1'b0);
      step();
      n_checks++;
      if (n_pop - p0 !== NELEM) begin
         n_fail++;
         $display("FAIL single_count: got %0d expected %0d", n_pop - p0, NELEM);
      end
      n_checks++;
      if ({busy, bus.in_ready, n_done == d0} !== 3'b111) begin
         n_fail++;
         $display("FAIL single_after: got busy=%b in_ready=%b done_pulses=%0d expected 1 1 0",
                  busy, bus.in_ready, n_done - d0);
      end
   endtask

   task automatic test_full_frame();
      int d0;
      do_reset();
      bus.out_ready = 1'b1;
      d0 = n_done;
      for (int c = 0; c < CHANNELS; c++) send_map(make_map(NELEM*c));
      drain(1'b0);
      step();
      step();
      n_checks++;
      if (n_done - d0 !== 1) begin
         n_fail++;
         $display("FAIL frame_done_count: got %0d expected 1", n_done - d0);
      end
      n_checks++;
      if (done_cyc - first_acc !== CHANNELS*(NELEM+1) - 1) begin
         n_fail++;
         $display("FAIL frame_timing: got %0d cycles expected %0d",
                  done_cyc - first_acc, CHANNELS*(NELEM+1) - 1);
      end
      n_checks++;
      if ({busy, bus.in_ready, done} !== 3'b010) begin
         n_fail++;
         $display("FAIL frame_after: got busy/in_ready/done=%b expected 010", {busy, bus.in_ready, done});
      end
   endtask

   task automatic test_backpressure();
      int p0;
      do_reset();
      bus.out_ready = 1'b0;
      p0 = n_pop;
      send_map(make_map(100));
      drain(1'b1);
      bus.out_ready = 1'b1;
      step();
      n_checks++;
      if (n_pop - p0 !== NELEM) begin
         n_fail++;
         $display("FAIL backpressure_count: got %0d expected %0d", n_pop - p0, NELEM);
      end
   endtask

   task automatic test_flush();
      int p0;
      int i;
      do_reset();
      bus.out_ready = 1'b1;
      send_map(make_map(0));
      send_map(make_map(NELEM));
      send_map(make_map(2*NELEM));
      p0 = n_pop;
      i  = 0;
      while (n_pop - p0 < 11 && i < 200) begin
         step();
         i++;
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_checks++;
      if ({bus.in_ready, bus.out_valid, busy, done} !== 4'b1000) begin
         n_fail++;
         $display("FAIL flush_after: got ready/valid/busy/done=%b expected 1000",
                  {bus.in_ready, bus.out_valid, busy, done});
      end
      repeat (3) step();
      send_map(make_map(200));
      n_checks++;
      if ({bus.out_valid, bus.out_index, bus.out_data} !== {1'b1, IDX_W'(0), 8'd200}) begin
         n_fail++;
         $display("FAIL flush_restart: got valid=%b idx=%0d data=%0d expected 1 0 200",
                  bus.out_valid, bus.out_index, bus.out_data);
      end
      drain(1'b0);
      step();
   endtask

   task automatic test_reset_mid_stream();
      do_reset();
      bus.out_ready = 1'b0;
      send_map(make_map(50));
      repeat (3) step();
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_map   = make_map(7);
      step();
      n_checks++;
      if ({bus.in_ready, bus.out_valid, busy, done, bus.out_last} !== 5'b10000) begin
         n_fail++;
         $display("FAIL midrst_ctrl: got ready/valid/busy/done/last=%b expected 10000",
                  {bus.in_ready, bus.out_valid, busy, done, bus.out_last});
      end
      n_checks++;
      if ({bus.out_data, bus.out_index} !== '0) begin
         n_fail++;
         $display("FAIL midrst_data: got data=%0d idx=%0d expected 0 0", bus.out_data, bus.out_index);
      end
      step();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      step();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_accept: got out_valid=%b expected 0", bus.out_valid);
      end
      bus.out_ready = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_map();
      test_full_frame();
      test_backpressure();
      test_flush();
      test_reset_mid_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
